mult_bus_if: RTL and testbench
==============================

// Module: mult_bus_if
// PURPOSE
//  Bus-side front end of the shift-add multiplier peripheral. Holds operands A/B written by the CPU,
//  issues a single-cycle start to the multiplier controller/datapath, waits for its done, and captures
//  the product into a CPU-readable register. Also provides a sticky done/error status register.
//  Sits between the femtoRV peripheral address decoder and the multiplier core.
// PARAMETERS
//  WIDTH    16   operand width in bits; the product is 2*WIDTH bits (2*WIDTH <= 64)
//  TIMEOUT  255  maximum number of cycles in WAIT before the operation is aborted; 8-bit counter
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  cs           in   1        chip select from address decoder
//  rd           in   1        read strobe (qualified by cs)
//  wr           in   1        write strobe (qualified by cs)
//  addr         in   5        byte address; word select = addr[4:2]
//  d_in         in   32       write data
//  d_out        out  32       read data, registered
//  core_A       out  WIDTH    operand A to core, held stable while busy
//  core_B       out  WIDTH    operand B to core, held stable while busy
//  core_init    out  1        start pulse to core, exactly 1 cycle
//  core_rst     out  1        core reset = rst OR 1-cycle abort pulse
//  core_done    in   1        core done (held high for several cycles by the core)
//  core_result  in   2*WIDTH  product from core datapath
// BEHAVIOUR
//  Register map (addr[4:2]): 0 A (R/W), 1 B (R/W), 2 CTRL (W: bit0 = start), 3 STATUS (R: bit0 busy,
//   bit1 done, bit2 err), 4 RES_LO (R: result[31:0]), 5 RES_HI (R: result[2*WIDTH-1:32], zero-extended).
//   Other words read 0; writes to them are ignored.
//  Reset: A=B=0, result=0, done=err=0, d_out=0, core_init=0, core_rst=1 while rst, FSM=IDLE.
//  Reads: d_out is updated the cycle after cs&rd; it holds its value when there is no read.
//  Writes to A/B while busy are ignored. A start write while busy is ignored.
//  FSM:
//   IDLE  : on cs&wr to CTRL with d_in[0]=1: clear done and err, go to ISSUE.
//   ISSUE : core_init=1 for this cycle only; clear the timeout counter; go to WAIT.
//   WAIT  : count cycles. When core_done=1, latch core_result and go to CAP.
//           When count==TIMEOUT, set err, pulse core_rst for 1 cycle, and go to IDLE.
//   CAP   : set done=1; go to DRAIN.
//   DRAIN : stay until core_done=0, then go to IDLE. This prevents double capture from the long done.
//  busy = (state != IDLE). Start-to-done latency = core latency + 2 cycles.
//  core_done high while in IDLE or ISSUE is ignored.
//  rst asserted mid-operation: return to IDLE immediately; done/err/result cleared.
//  Simultaneous read of STATUS and the FSM setting done: the read returns the pre-update value.
//  done and err are sticky until the next accepted start or rst.
// CONFIGURATION
//  MULT_IRQ_EN defined:
//   - adds output port irq (1 bit), reset value 0.
//   - irq goes high when done or err is set and stays high until the next start or rst.
//   - STATUS bit3 is an irq-enable bit, writable via CTRL d_in[1]; irq = (done|err) & ien.
//  MULT_IRQ_EN undefined: no irq port; STATUS bit3 reads 0; CTRL d_in[1] is ignored.
// TESTING
//  1. Write A=7, B=9, start; core model returns done after 20 cycles -> RES_LO=63, STATUS=0x2,
//     core_init high exactly 1 cycle.
//  2. A=0xFFFF, B=0xFFFF, start -> RES_LO=0xFFFE0001, RES_HI=0; done set; busy clears after
//     core_done falls.
//  3. Core model never raises core_done, TIMEOUT=255 -> err=1 at cycle 256 after ISSUE,
//     1-cycle core_rst pulse, busy=0, done=0.
//  4. While busy, write A=5 and start again -> A unchanged, no second core_init pulse,
//     first result is correct.
//  5. Core holds done for 15 cycles -> result captured once; a start immediately after DRAIN is
//     accepted and completes normally.
//  6. Assert rst during WAIT -> next cycle state=IDLE, STATUS=0, RES_LO=0; with MULT_IRQ_EN:
//     ien=1, so irq rises with done in test 1 and clears on the next start.

Source files
------------

// File: rtl/mult_bus_if.sv
// mult_bus_if -- bus-side front end of the shift-add multiplier peripheral.
//
// The CPU writes operands A and B and then writes a start bit to CTRL. The block
// issues a one-cycle core_init to the multiplier core and waits for core_done. It
// then captures core_result into a readable result register and sets a sticky
// done flag. If the core stays silent for TIMEOUT cycles, the operation is
// aborted: err is set and core_rst is pulsed for one cycle.
//
// Register map (word = addr[4:2]):
//   0 A (R/W)   1 B (R/W)   2 CTRL (W: bit0 start, bit1 irq enable)
//   3 STATUS (R: bit0 busy, bit1 done, bit2 err, bit3 irq enable)
//   4 RES_LO (R)   5 RES_HI (R, zero-extended)   other words read 0
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cs, rd, wr, addr  bus strobes and byte address from the peripheral decoder
//   d_in / d_out      write data / registered read data
//   core_A, core_B    operands to the core, stable while busy
//   core_init         one-cycle start pulse to the core
//   core_rst          core reset: rst or a one-cycle abort pulse
//   core_done         done from the core (may be held high for many cycles)
//   core_result       2*WIDTH-bit product from the core
//   irq               (only when MULT_IRQ_EN is defined) (done|err) & irq enable
//
// Optional feature macro: MULT_IRQ_EN adds the irq port and the irq-enable bit.
module mult_bus_if #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [4:0]         addr,
  input  logic [31:0]        d_in,
  output logic [31:0]        d_out,
  output logic [WIDTH-1:0]   core_A,
  output logic [WIDTH-1:0]   core_B,
  output logic               core_init,
  output logic               core_rst,
  input  logic               core_done,
  input  logic [2*WIDTH-1:0] core_result
`ifdef MULT_IRQ_EN
  ,
  output logic               irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        dout_q, dout_d;
  logic               ien_q, ien_d;

  logic        wr_en, rd_en, start_req, busy, abort;
  logic [2:0]  word;
  logic [63:0] res_ext;
  logic [31:0] status;
  logic        unused_bits;

  assign word      = addr[4:2];
  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign start_req = wr_en && (word == 3'd2) && d_in[0];
  assign busy      = (state_q != S_IDLE);
  // A done arriving in the same cycle as the count limit wins over the timeout.
  assign abort     = (state_q == S_WAIT) && !core_done && (cnt_q == TMO);

  // Byte-lane bits and the upper data bits are not needed by this block.
  assign unused_bits = ^{addr[1:0], d_in};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done)  state_d = S_CAP;
        else if (abort) state_d = S_IDLE;
      end
      S_CAP:   state_d = S_DRAIN;
      // Hold here until the core drops its long done, so it is captured only once.
      S_DRAIN: if (!core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    core_init = (state_q == S_ISSUE);
    core_rst  = rst | abort;
  end

  assign core_A = a_q;
  assign core_B = b_q;
  assign d_out  = dout_q;

`ifdef MULT_IRQ_EN
  assign irq = (done_q | err_q) & ien_q;
`endif

  always_comb begin
    res_ext                = '0;
    res_ext[2*WIDTH-1:0]   = res_q;
`ifdef MULT_IRQ_EN
    status = {28'd0, ien_q, err_q, done_q, busy};
`else
    status = {28'd0, 1'b0, err_q, done_q, busy};
`endif
  end

  // Register updates
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    done_d = done_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ien_d  = ien_q;

    if (wr_en && !busy && (word == 3'd0)) a_d = d_in[WIDTH-1:0];
    if (wr_en && !busy && (word == 3'd1)) b_d = d_in[WIDTH-1:0];
`ifdef MULT_IRQ_EN
    if (wr_en && (word == 3'd2)) ien_d = d_in[1];
`endif

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      S_ISSUE: cnt_d = 8'd0;
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (core_done) res_d = core_result;
        if (abort)     err_d = 1'b1;
      end
      S_CAP:   done_d = 1'b1;
      default: ;
    endcase

    // Reads use the current register values, so a read that coincides with a
    // status update returns the value from before the update.
    if (rd_en) begin
      case (word)
        3'd0:    dout_d = 32'(a_q);
        3'd1:    dout_d = 32'(b_q);
        3'd3:    dout_d = status;
        3'd4:    dout_d = res_ext[31:0];
        3'd5:    dout_d = res_ext[63:32];
        default: dout_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= 8'd0;
      dout_q <= 32'd0;
      ien_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ien_q  <= ien_d;
    end
  end

endmodule

// File: tb/tb_mult_bus_if.sv
// Testbench for mult_bus_if: bus tasks drive the register interface, and a
// behavioural core model answers core_init with a delayed, held done. Every
// read pushes its expected value into a queue. A monitor pops that queue and
// compares it against d_out one cycle after the read strobe.
module tb_mult_bus_if;
  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst, cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_in, d_out;
  logic [WIDTH-1:0] core_A, core_B;
  logic        core_init, core_rst;
  logic        core_done = 1'b0;
  logic [2*WIDTH-1:0] core_result = '0;
`ifdef MULT_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mult_bus_if #(.WIDTH(WIDTH), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .core_A(core_A), .core_B(core_B),
    .core_init(core_init), .core_rst(core_rst), .core_done(core_done),
    .core_result(core_result)
`ifdef MULT_IRQ_EN
    , .irq(irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  int  lat = 20, hold = 3;
  bit  never = 1'b0;
  int  ccnt = 0;
  bit  cact = 1'b0;
  always @(posedge clk) begin
    if (rst || core_rst) begin
      cact <= 1'b0; ccnt <= 0; core_done <= 1'b0;
    end else if (core_init) begin
      cact <= 1'b1; ccnt <= 0; core_done <= 1'b0;
      core_result <= 32'(core_A) * 32'(core_B);
    end else if (cact && !never) begin
      ccnt <= ccnt + 1;
      if (ccnt + 1 == lat) core_done <= 1'b1;
      if (ccnt + 1 == lat + hold) begin core_done <= 1'b0; cact <= 1'b0; end
    end
  end

  // ---------------- event monitor ----------------
  int cyc = 0;
  int init_cnt = 0, crst_cnt = 0, t_init = 0, t_crst = 0;
  bit prev_init = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_init) begin
        chk("init_one_cycle", prev_init, 0);
        init_cnt++; t_init = cyc;
      end
      if (core_rst) begin crst_cnt++; t_crst = cyc; end
    end
    prev_init = core_init;
  end

  // ---------------- read scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_vld = 1'b0;
  string       mon_n;
  logic [31:0] mon_e;
  always @(posedge clk) rd_vld <= cs & rd & !rst;
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_read", 1, 0);
      end else begin
        mon_n = name_q.pop_front();
        mon_e = exp_q.pop_front();
        chk(mon_n, d_out, mon_e);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [63:0]      m_res = '0;
  bit m_done = 1'b0, m_err = 1'b0, m_ien = 1'b0;

  function automatic logic [31:0] exp_status(input bit busy);
    return {28'd0, m_ien, m_err, m_done, busy};
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_done = 0; m_err = 0; m_ien = 0;
  endtask

  // ---------------- bus tasks ----------------
  task automatic wr_word(input int w, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 5'(w * 4); d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_word(input int w, input logic [31:0] e, input string n);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 5'(w * 4);
    exp_q.push_back(e); name_q.push_back(n);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    wr_word(0, 32'(a)); m_a = a;
    wr_word(1, 32'(b)); m_b = b;
  endtask

  // Start with irq enable requested too; it only sticks when the feature exists.
  task automatic start_op();
    wr_word(2, 32'h3);
    m_done = 0; m_err = 0;
`ifdef MULT_IRQ_EN
    m_ien = 1;
    chk("irq_clear_on_start", irq, 0);
`endif
  endtask

  task automatic check_irq();
`ifdef MULT_IRQ_EN
    chk("irq_level", irq, (m_done | m_err) & m_ien);
`endif
  endtask

  task automatic wait_core_done(input logic lvl, input int budget, input string n);
    int k = 0;
    while (core_done !== lvl && k < budget) begin @(negedge clk); k++; end
    chk(n, core_done, lvl);
  endtask

  task automatic finish_results();
    m_res = {48'd0, m_a} * {48'd0, m_b};
    m_done = 1;
    rd_word(4, m_res[31:0], "res_lo");
    rd_word(5, m_res[63:32], "res_hi");
    rd_word(3, exp_status(0), "status_done");
    check_irq();
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int l, input int h);
    int base;
    lat = l; hold = h; never = 0;
    set_ops(a, b);
    base = init_cnt;
    start_op();
    repeat (l + h + 8) @(negedge clk);
    chk("init_pulses", init_cnt - base, 1);
    finish_results();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, k;
    rst = 1'b1; cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_init", core_init, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_core_A", core_A, 0);
    rst = 1'b0;
    rd_word(3, 32'd0, "rst_status");
    rd_word(4, 32'd0, "rst_res_lo");
    rd_word(0, 32'd0, "rst_a");

    // 1: basic product
    do_op(16'd7, 16'd9, 20, 3);
    rd_word(0, 32'd7, "a_readback");
    rd_word(1, 32'd9, "b_readback");

    // 2: max operands, status while core still holds done
    lat = 10; hold = 15; never = 0;
    set_ops(16'hFFFF, 16'hFFFF);
    start_op();
    wait_core_done(1'b1, 100, "t2_done_rise");
    repeat (4) @(negedge clk);
    m_done = 1;
    rd_word(3, exp_status(1), "t2_status_drain");
    repeat (25) @(negedge clk);
    finish_results();
    chk("t2_res_model", m_res[31:0], 32'hFFFE0001);

    // 3: core never answers -> timeout
    never = 1;
    set_ops(16'($urandom), 16'($urandom));
    base = crst_cnt;
    start_op();
    k = 0;
    while (crst_cnt == base && k < 400) begin @(negedge clk); k++; end
    chk("t3_abort_seen", crst_cnt != base, 1);
    chk("t3_abort_cycle", t_crst - t_init, 256);
    repeat (5) @(negedge clk);
    chk("t3_abort_pulses", crst_cnt - base, 1);
    m_err = 1;
    rd_word(3, exp_status(0), "t3_status_err");
    check_irq();
    never = 0;

    // 4: writes while busy are ignored
    lat = 20; hold = 3;
    set_ops(16'd11, 16'd13);
    base = init_cnt;
    start_op();
    wr_word(0, 32'd5);
    wr_word(2, 32'h3);
    rd_word(3, exp_status(1), "t4_status_busy");
    repeat (35) @(negedge clk);
    chk("t4_init_pulses", init_cnt - base, 1);
    rd_word(0, 32'd11, "t4_a_kept");
    finish_results();

    // 5: long done captured once, restart right after drain
    lat = 5; hold = 15;
    set_ops(16'($urandom), 16'($urandom));
    base = init_cnt;
    start_op();
    wait_core_done(1'b1, 60, "t5_done_rise");
    wait_core_done(1'b0, 60, "t5_done_fall");
    chk("t5_init_pulses", init_cnt - base, 1);
    base2 = init_cnt;
    start_op();
    repeat (30) @(negedge clk);
    chk("t5_restart_pulses", init_cnt - base2, 1);
    finish_results();

    // unmapped words
    wr_word(7, 32'hDEADBEEF);
    wr_word(3, 32'hFFFFFFFF);
    rd_word(7, 32'd0, "unmapped_7");
    rd_word(6, 32'd0, "unmapped_6");
    rd_word(3, exp_status(0), "status_after_junk");

    // randomized operations
    for (int i = 0; i < 6; i++)
      do_op(16'($urandom), 16'($urandom), $urandom_range(1, 25), $urandom_range(1, 8));

    // 6: reset during WAIT
    lat = 20; hold = 3;
    set_ops(16'h1234, 16'h0011);
    start_op();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_core_rst", core_rst, 1);
    rst = 1'b0;
    model_reset();
    rd_word(3, 32'd0, "t6_status");
    rd_word(4, 32'd0, "t6_res_lo");
    rd_word(0, 32'd0, "t6_a");
    check_irq();

    do_op(16'($urandom), 16'($urandom), 12, 4);

    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
